// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU and one unified memory port.
// Each instruction is sequenced by a Moore FSM and takes 3-5 clocks.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_in,
  output logic [31:0] address,
  output logic [31:0] mem_out,
  output logic        mem_read,
  output logic        mem_write
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EX, R_WB, I_EX, I_WB, MEM_ADDR,
    LW_RD, LW_WB, SW_WR, BEQ, JUMP
  } state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  state_e      state_q;
  logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [31:0] rf_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, zext;
  logic        r_known, is_jr;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext  = {16'h0, ir_q[15:0]};
  assign is_jr = (funct == 6'h08);
  assign r_known = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                   (funct == 6'h25) || (funct == 6'h2A) || is_jr;

  // Shared ALU: operand and operation selection depend only on the state.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_e     alu_op;

  always_comb begin
    alu_a  = pc_q;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    unique case (state_q)
      DECODE: alu_b = {sext[29:0], 2'b00};
      R_EX: begin
        alu_a = a_q;
        alu_b = b_q;
        unique case (funct)
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      I_EX: begin
        alu_a = a_q;
        alu_b = (op == 6'h0C || op == 6'h0D) ? zext : sext;
        unique case (op)
          6'h0A:   alu_op = ALU_SLT;
          6'h0C:   alu_op = ALU_AND;
          6'h0D:   alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      MEM_ADDR: begin
        alu_a = a_q;
        alu_b = sext;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // Memory port is decoded from the state alone, so async reset drops strobes at once.
  assign address   = (state_q == LW_RD || state_q == SW_WR) ? aluout_q : pc_q;
  assign mem_read  = (state_q == FETCH) || (state_q == LW_RD);
  assign mem_write = (state_q == SW_WR);
  assign mem_out   = b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          ir_q    <= mem_in;
          pc_q    <= alu_y;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q      <= rf_q[rs];
          b_q      <= rf_q[rt];
          aluout_q <= alu_y;
          unique case (op)
            6'h00:                      state_q <= r_known ? R_EX : FETCH;
            6'h08, 6'h0A, 6'h0C, 6'h0D: state_q <= I_EX;
            6'h23, 6'h2B:               state_q <= MEM_ADDR;
            6'h04:                      state_q <= BEQ;
            6'h02, 6'h03:               state_q <= JUMP;
            default:                    state_q <= FETCH;
          endcase
        end
        R_EX: begin
          if (is_jr) begin
            pc_q    <= a_q;
            state_q <= FETCH;
          end else begin
            aluout_q <= alu_y;
            state_q  <= R_WB;
          end
        end
        R_WB: begin
          if (rd != 5'd0) rf_q[rd] <= aluout_q;
          state_q <= FETCH;
        end
        I_EX: begin
          aluout_q <= alu_y;
          state_q  <= I_WB;
        end
        I_WB: begin
          if (rt != 5'd0) rf_q[rt] <= aluout_q;
          state_q <= FETCH;
        end
        MEM_ADDR: begin
          aluout_q <= alu_y;
          state_q  <= (op == 6'h23) ? LW_RD : SW_WR;
        end
        LW_RD: begin
          mdr_q   <= mem_in;
          state_q <= LW_WB;
        end
        LW_WB: begin
          if (rt != 5'd0) rf_q[rt] <= mdr_q;
          state_q <= FETCH;
        end
        SW_WR: state_q <= FETCH;
        BEQ: begin
          if (a_q == b_q) pc_q <= aluout_q;
          state_q <= FETCH;
        end
        JUMP: begin
          pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
          if (op == 6'h03) rf_q[31] <= pc_q;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed program bench: a behavioural memory, per-instruction cycle/PC checks
// and a scoreboard of expected memory writes.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_in, address, mem_out;
  logic        mem_read, mem_write;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rom [256];
  logic [31:0] ram [256];
  bit          ram_vld [256];
  logic [63:0] wr_q [$];

  mips_multicycle_core dut (
    .clk(clk), .rst(rst), .mem_in(mem_in), .address(address),
    .mem_out(mem_out), .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  assign mem_in = ram_vld[address[9:2]] ? ram[address[9:2]] : rom[address[9:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      ram[address[9:2]]     <= mem_out;
      ram_vld[address[9:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected (address, data) pair.
  always @(negedge clk) begin
    if (rst) begin
      chk("rd_wr_excl", {31'h0, mem_read & mem_write}, 32'h0);
      if (mem_write) begin
        if (wr_q.size() == 0) chk("unexpected_write", address, 32'hFFFF_FFFF);
        else begin
          logic [63:0] e;
          e = wr_q.pop_front();
          chk("wr_addr", address, e[63:32]);
          chk("wr_data", mem_out, e[31:0]);
        end
      end
    end
  end

  task automatic step(input int n, input logic [31:0] pc, input string tag);
    repeat (n) @(posedge clk);
    #1;
    chk({tag, "_pc"}, address, pc);
    chk({tag, "_rd"}, {31'h0, mem_read}, 32'h1);
  endtask

  function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rty(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] jty(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  int          sw_reg [11] = '{4, 5, 6, 9, 10, 11, 12, 13, 0, 31, 3};
  logic [31:0] sw_exp [11] = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'h30, 32'hFC, 32'h0000_FFFE,
                               32'h8000, 32'd1, 32'd0, 32'h24, 32'd12};

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 32'h0;
      ram[i] = 32'h0;
    end
    rom[0]  = ity(6'h08, 0, 1, 16'd5);
    rom[1]  = ity(6'h08, 0, 2, 16'd7);
    rom[2]  = rty(1, 2, 3, 6'h20);
    rom[3]  = ity(6'h2B, 0, 3, 16'd100);
    rom[4]  = ity(6'h23, 0, 4, 16'd100);
    rom[5]  = rty(1, 2, 5, 6'h22);
    rom[6]  = rty(5, 1, 6, 6'h2A);
    rom[7]  = ity(6'h04, 1, 2, 16'd5);
    rom[8]  = jty(6'h03, 26'h10);
    rom[9]  = ity(6'h08, 14, 14, 16'd1);
    rom[10] = ity(6'h04, 14, 14, 16'hFFFE);
    rom[16] = ity(6'h08, 0, 7, 16'hF0);
    rom[17] = ity(6'h08, 0, 8, 16'h3C);
    rom[18] = rty(7, 8, 9, 6'h24);
    rom[19] = rty(7, 8, 10, 6'h25);
    rom[20] = ity(6'h0C, 5, 11, 16'hFFFF);
    rom[21] = ity(6'h0D, 0, 12, 16'h8000);
    rom[22] = ity(6'h0A, 5, 13, 16'hFFFF);
    rom[23] = ity(6'h08, 0, 0, 16'd9);
    rom[24] = jty(6'h02, 26'h20);
    rom[32] = 32'hFC00_0000;
    rom[33] = rty(1, 2, 3, 6'h3F);
    for (int i = 0; i < 11; i++) rom[34 + i] = ity(6'h2B, 0, sw_reg[i][4:0], 16'h200 + 16'(4 * i));
    rom[45] = rty(31, 0, 0, 6'h08);

    // Reset state
    #1;
    chk("rst_addr", address, 32'h0);
    chk("rst_rd", {31'h0, mem_read}, 32'h1);
    chk("rst_wr", {31'h0, mem_write}, 32'h0);
    chk("rst_out", mem_out, 32'h0);
    #21 rst = 1'b1;

    step(4, 32'h04, "addi1");
    step(4, 32'h08, "addi2");
    step(4, 32'h0C, "add");
    chk("r3_sum", dut.rf_q[3], 32'd12);
    chk("pc_12", dut.pc_q, 32'd12);

    wr_q.push_back({32'd100, 32'd12});
    step(4, 32'h10, "sw");
    repeat (3) @(posedge clk);
    #1;
    chk("lw_rd_addr", address, 32'd100);
    chk("lw_rd_strobe", {31'h0, mem_read}, 32'h1);
    step(2, 32'h14, "lw");
    step(4, 32'h18, "sub");
    step(4, 32'h1C, "slt");
    step(3, 32'h20, "beq_nt");
    step(3, 32'h40, "jal");
    step(4, 32'h44, "addi_f0");
    step(4, 32'h48, "addi_3c");
    step(4, 32'h4C, "and");
    step(4, 32'h50, "or");
    step(4, 32'h54, "andi");
    step(4, 32'h58, "ori");
    step(4, 32'h5C, "slti");
    step(4, 32'h60, "addi_r0");
    step(3, 32'h80, "j");
    step(2, 32'h84, "bad_op");
    step(2, 32'h88, "bad_fn");
    for (int i = 0; i < 11; i++) begin
      wr_q.push_back({32'h200 + 32'(4 * i), sw_exp[i]});
      step(4, 32'h8C + 32'(4 * i), "sw_dump");
    end
    step(3, 32'h24, "jr");
    step(4, 32'h28, "loop_addi");
    step(3, 32'h24, "beq_t");
    step(4, 32'h28, "loop_addi2");
    step(3, 32'h24, "beq_t2");
    chk("r14_loop", dut.rf_q[14], 32'd2);
    chk("sb_empty", 32'(wr_q.size()), 32'd0);

    // Async reset while in SW_WR
    @(negedge clk);
    rst = 1'b0;
    #10 rst = 1'b1;
    chk("rf_cleared", dut.rf_q[3], 32'd0);
    step(4, 32'h04, "re_addi1");
    step(4, 32'h08, "re_addi2");
    step(4, 32'h0C, "re_add");
    repeat (3) @(posedge clk);
    #1;
    chk("sw_wr_strobe", {31'h0, mem_write}, 32'h1);
    chk("sw_wr_addr", address, 32'd100);
    #1 rst = 1'b0;
    #1;
    chk("arst_wr", {31'h0, mem_write}, 32'h0);
    chk("arst_addr", address, 32'h0);
    chk("arst_rd", {31'h0, mem_read}, 32'h1);
    chk("arst_pc", dut.pc_q, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(4, 32'h04, "post_rst");
    chk("sb_final", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multi-cycle 32-bit MIPS processor core. Uses one unified instruction/data memory port; the memory sits outside the block. Each instruction runs through a Moore FSM in 3-5 clocks, sharing one ALU and one memory port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising-edge active.
rst  in  1  asynchronous, active-low reset. rst=0 resets the core.
mem_in  in  32  read data from memory. Combinational: valid in the same cycle as address.
address  out  32  byte address to memory.
mem_out  out  32  write data to memory.
mem_read  out  1  read strobe.
mem_write  out  1  write strobe. Memory writes on the clk edge while this is high.

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, PC=RESET_PC.
  - IR, A, B, ALUOut, MDR = 0.
  - Register file all zero.
  - Outputs during reset: address=RESET_PC, mem_read=1, mem_write=0, mem_out=0.
- Register file: 32x32. $0 reads 0 and ignores writes. Writes happen on the clk edge.
- Datapath registers: PC, IR, MDR, A, B, ALUOut.
- ALU ops: add, sub, and, or, slt (signed). zero flag = (A==B).
- Immediates:
  - Sign-extended for addi, slti, lw, sw, beq.
  - Zero-extended for andi, ori.
- Supported instructions:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D.
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- FSM states and transitions:
  - FETCH: address=PC, mem_read=1. IR<=mem_in; PC<=PC+4. Next DECODE.
  - DECODE: A<=R[rs]; B<=R[rt]; ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode.
  - R_EX: ALUOut<=A funct B. Next R_WB. For jr: PC<=A, next FETCH.
  - R_WB: R[rd]<=ALUOut. Next FETCH.
  - I_EX: ALUOut<=A op ext(imm). Next I_WB.
  - I_WB: R[rt]<=ALUOut. Next FETCH.
  - MEM_ADDR: ALUOut<=A+sext(imm). Next LW_RD for lw, SW_WR for sw.
  - LW_RD: address=ALUOut, mem_read=1, MDR<=mem_in. Next LW_WB.
  - LW_WB: R[rt]<=MDR. Next FETCH.
  - SW_WR: address=ALUOut, mem_out=B, mem_write=1. Next FETCH.
  - BEQ: if A==B then PC<=ALUOut. Next FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}. For jal, also R[31]<=PC (already PC+4). Next FETCH.
- Cycle counts:
  - beq, j, jal, jr: 3.
  - R-type, I-ALU, sw: 4.
  - lw: 5.
- Output defaults: mem_read=0, mem_write=0 outside the listed states. mem_out=B always. address=PC except in LW_RD and SW_WR.
- mem_read and mem_write are never high in the same cycle.
- Unknown opcode or funct: no register or memory write. Returns DECODE->FETCH (2 cycles, behaves as NOP).
- Arithmetic: add/sub wrap modulo 2^32; no overflow trap.
- PC wraps modulo 2^32.
- Reset mid-instruction aborts it immediately; no partial write completes after rst falls.

Test Plan:
- Reset/fetch: hold rst=0 for 20 ns, then release -> first FETCH has address=0, mem_read=1. After 3 instructions (addi $1,$0,5 / addi $2,$0,7 / add $3,$1,$2), $3=12 and PC=12 after 12 cycles.
- Memory ops: sw $3,100($0) -> mem_write=1 for exactly one cycle, address=100, mem_out=12. Then lw $4,100($0) -> $4=12, 5 cycles, mem_read high in FETCH and LW_RD.
- Branch: beq $1,$1,-2 -> PC returns to the branch target, loop repeats. beq $1,$2,x with 5≠7 -> falls through to PC+4.
- ALU set: sub $5,$1,$2 -> 0xFFFFFFFE. slt $6,$5,$1 -> 1. and/or of 0xF0 and 0x3C -> 0x30 and 0xFC. andi with imm 0xFFFF uses zero-extension.
- Jumps: jal at 0x20 to target 0x40 -> $31=0x24, PC=0x40. jr $31 -> PC=0x24. Writes to $0 leave $0=0.
- Async reset: assert rst=0 in the middle of SW_WR -> mem_write drops without waiting for a clk edge, PC=0, state FETCH.
